// File: rtl/ex_stage_pipe_if.sv
// Handshake bundle between register-read, the EX stage and memory/writeback.
// master = surrounding pipeline (drives operands, out_ready); slave = EX stage.
interface ex_stage_pipe_if #(
  parameter int WIDTH = 20,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] instr_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] instr_out;
  logic             busy;

  modport master (
    output in_valid, op, op_a, op_b, instr_in, out_ready,
    input  in_ready, out_valid, result, zero, instr_out, busy
  );

  modport slave (
    input  in_valid, op, op_a, op_b, instr_in, out_ready,
    output in_ready, out_valid, result, zero, instr_out, busy
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: registered EX-stage ALU; EX_STAGE_MUL_EN adds an iterative shift-add MUL on op 111.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: in_ready drops while the output register is stalled, during reset, or while a MUL runs.
module ex_stage_pipe #(
  parameter int WIDTH = 20,
  parameter int OPW   = 3
) (
  input  logic               clock,
  input  logic               reset,
  ex_stage_pipe_if.slave     bus
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'd0);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3'd1);
  localparam logic [OPW-1:0] OP_AND = OPW'(3'd2);
  localparam logic [OPW-1:0] OP_NOT = OPW'(3'd3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3'd4);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3'd5);
  localparam logic [OPW-1:0] OP_SLT = OPW'(3'd6);
  localparam logic [OPW-1:0] OP_MUL = OPW'(3'd7);

  logic             accept;
  logic             drain;
  logic             idle;
  logic [WIDTH-1:0] alu_res;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] instr_q;

  logic             mul_start;
  logic             mul_last;
  logic [WIDTH-1:0] mul_res;
  logic             mul_zero;
  logic [WIDTH-1:0] mul_instr;

  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = out_valid_q && bus.out_ready;
  assign bus.in_ready  = !reset && idle && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.instr_out = instr_q;

  // Op 111 (and any unused encoding when OPW > 3) falls to zero here.
  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.op_a + bus.op_b;
      OP_OR:   alu_res = bus.op_a | bus.op_b;
      OP_AND:  alu_res = bus.op_a & bus.op_b;
      OP_NOT:  alu_res = ~bus.op_a;
      OP_SUB:  alu_res = bus.op_a - bus.op_b;
      OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      default: alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             zero_p;
  logic [WIDTH-1:0] instr_p;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (mul_start) state_nxt = MUL;
      MUL: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle      = (state == IDLE);
  assign bus.busy  = busy;
  assign mul_start = accept && (bus.op == OP_MUL);
  assign mul_last  = (state == MUL) && (cnt == LAST);
  // Final partial product is folded in combinationally so the result lands on the last MUL edge.
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_res   = acc_nxt;
  assign mul_zero  = zero_p;
  assign mul_instr = instr_p;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      zero_p  <= 1'b0;
      instr_p <= '0;
    end else if (mul_start) begin
      cnt     <= '0;
      mcand   <= bus.op_a;
      mplier  <= bus.op_b;
      acc     <= '0;
      zero_p  <= (bus.op_a == bus.op_b);
      instr_p <= bus.instr_in;
    end else if (state == MUL) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign idle      = 1'b1;
  assign bus.busy  = 1'b0;
  assign mul_start = 1'b0;
  assign mul_last  = 1'b0;
  assign mul_res   = '0;
  assign mul_zero  = 1'b0;
  assign mul_instr = '0;
`endif

  // A MUL accept only clears out_valid (via drain); the old result stays visible until MUL completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      instr_q     <= '0;
    end else if (mul_last) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_res;
      zero_q      <= mul_zero;
      instr_q     <= mul_instr;
    end else if (accept && !mul_start) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      zero_q      <= (bus.op_a == bus.op_b);
      instr_q     <= bus.instr_in;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe (WIDTH=20): vector table for single-cycle ops plus
// hand-written stall, MUL (EX_STAGE_MUL_EN) and reset sequences.
module tb_ex_stage_pipe;

  localparam int W = 20;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;

  ex_stage_pipe_if #(.WIDTH(W), .OPW(3)) bus ();

  ex_stage_pipe #(.WIDTH(W), .OPW(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] instr;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] instr);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.instr_in = instr;
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] res, input logic z,
                         input logic [W-1:0] instr);
    chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, ".result"},    32'(bus.result),    32'(res));
    chk({name, ".zero"},      32'(bus.zero),      32'(z));
    chk({name, ".instr_out"}, 32'(bus.instr_out), 32'(instr));
  endtask

`ifdef EX_STAGE_MUL_EN
  task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] instr, input logic [W-1:0] res, input logic z);
    int bad;
    bad = 0;
    bus.out_ready = 1'b1;
    drive(3'b111, a, b, instr);
    chk({name, ".in_ready_start"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= W; i++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      tick();
    end
    chk({name, ".busy_window_bad_cycles"}, 32'(bad), 32'd0);
    chk({name, ".busy_after"}, 32'(bus.busy), 32'd0);
    chk_out(name, res, z, instr);
    tick();
    chk({name, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask
`endif

  initial begin
    n_chk = 0;
    n_err = 0;
    //          op      a         b         instr     res       z
    vecs[0]  = '{3'b000, 20'h00001, 20'h00001, 20'h11111, 20'h00002, 1'b1};
    vecs[1]  = '{3'b001, 20'hFFC00, 20'h00003, 20'h22222, 20'hFFC03, 1'b0};
    vecs[2]  = '{3'b000, 20'hFFFFF, 20'h00001, 20'h33333, 20'h00000, 1'b0};
    vecs[3]  = '{3'b100, 20'h00000, 20'h00001, 20'h44444, 20'hFFFFF, 1'b0};
    vecs[4]  = '{3'b110, 20'h80000, 20'h00001, 20'h55555, 20'h00001, 1'b0};
    vecs[5]  = '{3'b110, 20'h00001, 20'h80000, 20'h66666, 20'h00000, 1'b0};
    vecs[6]  = '{3'b011, 20'hFFC00, 20'h12345, 20'h77777, 20'h003FF, 1'b0};
    vecs[7]  = '{3'b010, 20'h00205, 20'h0000F, 20'h88888, 20'h00005, 1'b0};
    vecs[8]  = '{3'b101, 20'hA5A5A, 20'hFFFFF, 20'h99999, 20'h5A5A5, 1'b0};
    vecs[9]  = '{3'b100, 20'h12345, 20'h12345, 20'hAAAAA, 20'h00000, 1'b1};
    vecs[10] = '{3'b110, 20'hFFFFF, 20'hFFFFE, 20'hBBBBB, 20'h00000, 1'b0};
    vecs[11] = '{3'b110, 20'hFFFFE, 20'hFFFFF, 20'hCCCCC, 20'h00001, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.instr_in  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst.in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.result",    32'(bus.result),    32'd0);
    chk("rst.zero",      32'(bus.zero),      32'd0);
    chk("rst.instr_out", 32'(bus.instr_out), 32'd0);
    chk("rst.busy",      32'(bus.busy),      32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream: one op per cycle, each result visible the cycle after accept.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].instr);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].instr);
    end

    // Drain without accept: valid drops, data holds.
    bus.in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain.result",    32'(bus.result),    32'h00001);
    chk("drain.instr_out", 32'(bus.instr_out), 32'hCCCCC);

    // Backpressure: AND result must hold for three stalled cycles, then accept+drain with no bubble.
    drive(3'b010, 20'h00205, 20'h0000F, 20'h0ABCD);
    tick();
    chk_out("bp.first", 20'h00005, 1'b0, 20'h0ABCD);
    bus.out_ready = 1'b0;
    drive(3'b000, 20'h00010, 20'h00020, 20'h0DCBA);
    #1;
    chk("bp.in_ready_stall", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("bp.hold%0d", i), 20'h00005, 1'b0, 20'h0ABCD);
      chk($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    chk_out("bp.next", 20'h00030, 1'b0, 20'h0DCBA);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.empty", 32'(bus.out_valid), 32'd0);

`ifdef EX_STAGE_MUL_EN
    run_mul("mul3x5", 20'h00003, 20'h00005, 20'h01234, 20'h0000F, 1'b0);
    run_mul("mulwrap", 20'hFFFFF, 20'h00002, 20'h05678, 20'hFFFFE, 1'b0);
    run_mul("mulsq", 20'h00007, 20'h00007, 20'h09ABC, 20'h00031, 1'b1);

    // Reset at MUL cycle 7 aborts; outputs still hold the previous (nonzero) MUL result until then.
    drive(3'b111, 20'h00003, 20'h00005, 20'h0FFFF);
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    chk("abort.busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
`else
    drive(3'b111, 20'h00003, 20'h00005, 20'h01234);
    tick();
    chk_out("op7_off", 20'h00000, 1'b0, 20'h01234);
    chk("op7_off.busy", 32'(bus.busy), 32'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
`endif
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.result",    32'(bus.result),    32'd0);
    chk("abort.zero",      32'(bus.zero),      32'd0);
    chk("abort.instr_out", 32'(bus.instr_out), 32'd0);
    chk("abort.busy",      32'(bus.busy),      32'd0);
    chk("abort.in_ready",  32'(bus.in_ready),  32'd0);
    reset = 1'b0;
    drive(3'b101, 20'h0F0F0, 20'h00FF0, 20'h04321);
    tick();
    chk_out("after_abort", 20'h0FF00, 1'b0, 20'h04321);
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
